// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming SECDED decode sequencer:
// FSM state encoding, status flags and codeword data-bit positions.
package hamming_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_DEC,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_e;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_SGL  = 2'b01;
  localparam logic [1:0] FLAG_DBL  = 2'b10;

  localparam logic [15:0] DBL_RESULT = 16'h8000;

  // Data bits occupy codeword positions 15..9, 7..5 and 3.
  localparam int D_HI_MSB  = 15;
  localparam int D_HI_LSB  = 9;
  localparam int D_MID_MSB = 7;
  localparam int D_MID_LSB = 5;
  localparam int D_LO_POS  = 3;

  function automatic logic [10:0] get_data(
    input logic [15:0] w
  );
    return {w[D_HI_MSB:D_HI_LSB],
            w[D_MID_MSB:D_MID_LSB],
            w[D_LO_POS]};
  endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder for one 16-bit codeword.
// Ports: word_i (encoded word), result_o ({flag[1:0], 3'b0, data[10:0]}).
module hamming_secded_dec
  import hamming_pkg::*;
(
  input  logic [15:0] word_i,
  output logic [15:0] result_o
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;

  always_comb begin
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (word_i[k]) begin
        syn = syn ^ 4'(k);
      end
    end
  end

  assign par = ^word_i;

  // Syndrome 0 flips p0, leaving the data untouched.
  assign fixed = word_i ^ (16'd1 << syn);

  always_comb begin
    result_o = {FLAG_NONE, 3'b000, get_data(word_i)};
    unique case (1'b1)
      par: begin
        result_o = {FLAG_SGL, 3'b000, get_data(fixed)};
      end
      (!par && syn != 4'd0): begin
        result_o = DBL_RESULT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hamming_dec_sequencer.sv
// Walks NUM_WORDS encoded byte-pair words from SRC_BASE, decodes each
// with SECDED and writes byte-pair results to DST_BASE, then acks.
// Ports: clock, reset_n (async, active low), req (start), ack (done),
// mem_addr/mem_we/mem_wdata/mem_rdata (single data-memory port).
// Option: define ERR_COUNT_EN to add n_single/n_double error counters.
module hamming_dec_sequencer
  import hamming_pkg::*;
#(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int AW        = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0]    n_single,
  output logic [7:0]    n_double
`endif
);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   res_q, res_d;
  logic [15:0]   dec_res;
  logic [AW-1:0] idx2;
  logic [AW-1:0] src_a;
  logic [AW-1:0] dst_a;
  logic          last;

`ifdef ERR_COUNT_EN
  logic [7:0] nsgl_q, nsgl_d;
  logic [7:0] ndbl_q, ndbl_d;

  assign n_single = nsgl_q;
  assign n_double = ndbl_q;
`endif

  hamming_secded_dec u_dec (
    .word_i   ({hi_q, lo_q}),
    .result_o (dec_res)
  );

  // Address math wraps modulo 2^AW.
  assign idx2  = idx_q << 1;
  assign src_a = AW'(SRC_BASE) + idx2;
  assign dst_a = AW'(DST_BASE) + idx2;
  assign last  = (idx_q == AW'(NUM_WORDS - 1));

  assign ack = (state_q == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      res_q   <= '0;
`ifdef ERR_COUNT_EN
      nsgl_q  <= '0;
      ndbl_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      res_q   <= res_d;
`ifdef ERR_COUNT_EN
      nsgl_q  <= nsgl_d;
      ndbl_q  <= ndbl_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    res_d     = res_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
`ifdef ERR_COUNT_EN
    nsgl_d    = nsgl_q;
    ndbl_d    = ndbl_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (req) begin
          state_d = S_RD_LO;
          idx_d   = '0;
`ifdef ERR_COUNT_EN
          nsgl_d  = '0;
          ndbl_d  = '0;
`endif
        end
      end
      S_RD_LO: begin
        mem_addr = src_a;
        lo_d     = mem_rdata;
        state_d  = S_RD_HI;
      end
      S_RD_HI: begin
        mem_addr = src_a + AW'(1);
        hi_d     = mem_rdata;
        state_d  = S_DEC;
      end
      S_DEC: begin
        res_d   = dec_res;
        state_d = S_WR_LO;
`ifdef ERR_COUNT_EN
        if (dec_res[15:14] == FLAG_SGL) begin
          nsgl_d = nsgl_q + 8'd1;
        end
        if (dec_res[15:14] == FLAG_DBL) begin
          ndbl_d = ndbl_q + 8'd1;
        end
`endif
      end
      S_WR_LO: begin
        mem_addr  = dst_a;
        mem_we    = 1'b1;
        mem_wdata = res_q[7:0];
        state_d   = S_WR_HI;
      end
      S_WR_HI: begin
        mem_addr  = dst_a + AW'(1);
        mem_we    = 1'b1;
        mem_wdata = res_q[15:8];
        if (last) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_RD_LO;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hamming_dec_sequencer.sv
// Self-checking bench for hamming_dec_sequencer: table vectors,
// random SECDED words against an encoder-based model, req/reset corners.
module tb_hamming_dec_sequencer;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0;
  logic       ack;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef ERR_COUNT_EN
  logic [7:0] n_single;
  logic [7:0] n_double;
`endif

  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'd0;
  logic [7:0] tb_data = 8'd0;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [15:0] w;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [NW];
  logic [15:0] words [NW];
  logic [15:0] exps  [NW];

  hamming_dec_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .ack       (ack),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef ERR_COUNT_EN
    ,
    .n_single  (n_single),
    .n_double  (n_double)
`endif
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(posedge clock);
    #1;
    tb_we = 1'b0;
  endtask

  task automatic load();
    for (int i = 0; i < NW; i++) begin
      wr_byte(8'(SRC + 2 * i), words[i][7:0]);
      wr_byte(8'(SRC + 2 * i + 1), words[i][15:8]);
      wr_byte(8'(DST + 2 * i), 8'hAA);
      wr_byte(8'(DST + 2 * i + 1), 8'hAA);
    end
  endtask

  // Textbook Hamming(15,11) plus overall parity.
  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] w;
    int pos [11];
    logic x;
    pos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    w = '0;
    for (int i = 0; i < 11; i++) w[pos[i]] = d[i];
    for (int p = 0; p < 4; p++) begin
      x = 1'b0;
      for (int k = 3; k < 16; k++)
        if (((k >> p) & 1) == 1) x = x ^ w[k];
      w[1 << p] = x;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  task automatic run(input int inj_at, input int rst_at,
                     output int cyc, output int wes,
                     output bit aborted);
    @(negedge clock);
    req = 1'b1;
    @(posedge clock);
    #1;
    req = 1'b0;
    cyc = 0;
    wes = 0;
    aborted = 0;
`ifdef ERR_COUNT_EN
    chk("cnt_clr_sgl", n_single, 0);
    chk("cnt_clr_dbl", n_double, 0);
`endif
    while (!ack && cyc < 200) begin
      req = (cyc == inj_at);
      if (cyc == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        aborted = 1;
        break;
      end
      wes += int'(mem_we);
      @(posedge clock);
      #1;
      cyc++;
    end
    req = 1'b0;
    if (!aborted) chk("ack_seen", ack, 1);
  endtask

  task automatic check_results(input string tag);
    int ns, nd;
    ns = 0;
    nd = 0;
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("%s_res%0d", tag, i),
          {mem[DST + 2 * i + 1], mem[DST + 2 * i]}, exps[i]);
      if (exps[i][15:14] == 2'b01) ns++;
      if (exps[i][15:14] == 2'b10) nd++;
    end
`ifdef ERR_COUNT_EN
    chk({tag, "_nsgl"}, n_single, ns);
    chk({tag, "_ndbl"}, n_double, nd);
`endif
  endtask

  task automatic full_run(input string tag, input int inj_at);
    int cyc, wes;
    bit ab;
    load();
    run(inj_at, -1, cyc, wes, ab);
    chk({tag, "_cycles"}, cyc, 75);
    chk({tag, "_we_cycles"}, wes, 30);
    check_results(tag);
  endtask

  task automatic gen_random(input int ns, input int nd);
    int cls [NW];
    int j, t, b1, b2;
    logic [10:0] d;
    for (int i = 0; i < NW; i++)
      cls[i] = (i < ns) ? 1 : (i < ns + nd) ? 2 : 0;
    for (int i = NW - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = cls[i];
      cls[i] = cls[j];
      cls[j] = t;
    end
    for (int i = 0; i < NW; i++) begin
      d = 11'($urandom);
      words[i] = enc(d);
      exps[i] = {5'b00000, d};
      if (cls[i] == 1) begin
        b1 = $urandom_range(15, 0);
        words[i][b1] = ~words[i][b1];
        exps[i] = {5'b01000, d};
      end else if (cls[i] == 2) begin
        b1 = $urandom_range(15, 0);
        b2 = (b1 + $urandom_range(15, 1)) % 16;
        words[i][b1] = ~words[i][b1];
        words[i][b2] = ~words[i][b2];
        exps[i] = 16'h8000;
      end
    end
  endtask

  initial begin
    int cyc, wes;
    bit ab;

    tbl[0]  = '{16'h0020, 16'h4000};
    tbl[1]  = '{16'hFFFE, 16'h47FF};
    tbl[2]  = '{16'h0208, 16'h8000};
    tbl[3]  = '{16'hFFFF, 16'h07FF};
    tbl[4]  = '{16'h0000, 16'h0000};
    tbl[5]  = '{16'h0001, 16'h4000};
    tbl[6]  = '{16'h8000, 16'h4000};
    tbl[7]  = '{16'h7FFF, 16'h47FF};
    tbl[8]  = '{16'h0003, 16'h8000};
    tbl[9]  = '{16'hFFFC, 16'h8000};
    tbl[10] = '{16'h0007, 16'h4001};
    tbl[11] = '{16'h0008, 16'h4000};
    tbl[12] = '{16'h0009, 16'h8000};
    tbl[13] = '{16'h000F, 16'h0001};
    tbl[14] = '{16'hFFF0, 16'h07FE};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_ack", ack, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NW; i++) begin
      words[i] = 16'hFFFF;
      exps[i] = 16'h07FF;
    end
    full_run("ones", -1);

    for (int i = 0; i < NW; i++) begin
      words[i] = tbl[i].w;
      exps[i] = tbl[i].exp;
    end
    full_run("table", -1);

    for (int r = 0; r < 3; r++) begin
      gen_random(9, 4);
      full_run($sformatf("rand%0d", r), -1);
    end
    gen_random($urandom_range(8, 0), $urandom_range(6, 0));
    full_run("rand_mix", -1);

    for (int i = 0; i < NW; i++) begin
      words[i] = tbl[i].w;
      exps[i] = tbl[i].exp;
    end
    full_run("req_mid", 20);

    for (int i = 0; i < NW; i++) begin
      words[i] = 16'hFFFF;
      exps[i] = 16'h07FF;
    end
    load();
    run(-1, 40, cyc, wes, ab);
    chk("abort_taken", ab, 1);
    chk("abort_w7", {mem[DST + 15], mem[DST + 14]}, 16'h07FF);
    chk("abort_w8", {mem[DST + 17], mem[DST + 16]}, 16'hAAAA);
    @(negedge clock);
    chk("abort_ack_held", ack, 0);
    reset_n = 1'b1;
    gen_random(5, 5);
    full_run("after_rst", -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
